// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: next-PC source select, FSM states and default vectors.
// Also imported by decode so pc_sel is driven with the same encoding.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_JAL  = 2'd2,
        PC_JALR = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus decode-side control bundle between the sequencer and the core.
// master = sequencer side, slave = imem/decode side.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    pc_sel_t     pc_sel;
    logic        br_taken;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        ebreak;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] epc;
    logic        halted;
    logic [31:0] instret;

    modport master (
        output fetch_req, fetch_addr, pc, pc_plus4, trap, epc, halted, instret,
        input  fetch_ack, pc_sel, br_taken, imm, rs1_val, ebreak, resume
    );

    modport slave (
        input  fetch_req, fetch_addr, pc, pc_plus4, trap, epc, halted, instret,
        output fetch_ack, pc_sel, br_taken, imm, rs1_val, ebreak, resume
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection and misalignment detection.
// Zero latency, no state; all adds wrap modulo 2^32.
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_i,
    input  pc_sel_t     pc_sel_i,
    input  logic        br_taken_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_val_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic [31:0] seq_tgt;
    logic [31:0] rel_tgt;
    logic [31:0] jalr_sum;

    assign seq_tgt  = pc_i + 32'd4;
    assign rel_tgt  = pc_i + imm_i;
    assign jalr_sum = rs1_val_i + imm_i;

    always_comb begin
        target_o = seq_tgt;
        case (pc_sel_i)
            PC_SEQ:  target_o = seq_tgt;
            PC_BR:   target_o = br_taken_i ? rel_tgt : seq_tgt;
            PC_JAL:  target_o = rel_tgt;
            PC_JALR: target_o = jalr_sum & ~32'h1;
            default: target_o = seq_tgt;
        endcase
    end

    // JALR clears bit0 itself, so any low bit left here is a genuine fault.
    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC: BOOT/RUN/HALT FSM, fetch handshake, misaligned-target trap and instret.
// New PC visible one cycle after retire; stalls indefinitely while fetch_ack is low.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic [31:0] instret_q;
    logic        trap_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] instret_d;
    logic [31:0] target;
    logic        misaligned;
    logic        retire;

    pc_target_calc u_tgt (
        .pc_i         (pc_q),
        .pc_sel_i     (bus.pc_sel),
        .br_taken_i   (bus.br_taken),
        .imm_i        (bus.imm),
        .rs1_val_i    (bus.rs1_val),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    assign pc_plus4_d = pc_q + 32'd4;
    assign instret_d  = instret_q + 32'd1;
    assign retire     = (state_q == RUN) && bus.fetch_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (retire) begin
                        // EBREAK outranks a bad target: halt at the EBREAK itself.
                        if (bus.ebreak) begin
                            state_q   <= HALT;
                            instret_q <= instret_d;
                        end else if (misaligned) begin
                            pc_q   <= TRAP_VECTOR;
                            epc_q  <= pc_q;
                            trap_q <= 1'b1;
                        end else begin
                            pc_q      <= target;
                            instret_q <= instret_d;
                        end
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        pc_q    <= pc_plus4_d;
                        state_q <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.fetch_req  = (state_q == RUN);
    assign bus.fetch_addr = pc_q;
    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4_d;
    assign bus.trap       = trap_q;
    assign bus.epc        = epc_q;
    assign bus.halted     = (state_q == HALT);
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: one clock edge per table row, outputs sampled on the falling edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk;
    logic rst;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ack;
        pc_sel_t     sel;
        logic        br;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        eb;
        logic        res;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic        exp_trap;
        logic        exp_halted;
        logic [31:0] exp_instret;
        logic [31:0] exp_epc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic ack, input pc_sel_t sel, input logic br,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic eb, input logic res,
                                input logic [31:0] epc_e, input logic req_e, input logic trap_e,
                                input logic halted_e, input logic [31:0] instret_e,
                                input logic [31:0] pc_e);
        vec_t v;
        v.ack = ack; v.sel = sel; v.br = br; v.imm = imm; v.rs1 = rs1;
        v.eb = eb; v.res = res;
        v.exp_pc = pc_e; v.exp_req = req_e; v.exp_trap = trap_e;
        v.exp_halted = halted_e; v.exp_instret = instret_e; v.exp_epc = epc_e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc_e, input logic req_e,
                             input logic trap_e, input logic halted_e,
                             input logic [31:0] instret_e, input logic [31:0] epc_e);
        chk({tag, ".pc"},         bus.pc,                 pc_e);
        chk({tag, ".fetch_addr"}, bus.fetch_addr,         pc_e);
        chk({tag, ".pc_plus4"},   bus.pc_plus4,           pc_e + 32'd4);
        chk({tag, ".fetch_req"},  {31'd0, bus.fetch_req}, {31'd0, req_e});
        chk({tag, ".trap"},       {31'd0, bus.trap},      {31'd0, trap_e});
        chk({tag, ".halted"},     {31'd0, bus.halted},    {31'd0, halted_e});
        chk({tag, ".instret"},    bus.instret,            instret_e);
        chk({tag, ".epc"},        bus.epc,                epc_e);
    endtask

    task automatic drive(input vec_t v);
        bus.fetch_ack = v.ack;
        bus.pc_sel    = v.sel;
        bus.br_taken  = v.br;
        bus.imm       = v.imm;
        bus.rs1_val   = v.rs1;
        bus.ebreak    = v.eb;
        bus.resume    = v.res;
    endtask

    // Called on a falling edge: drive, take one rising edge, sample on the next falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        @(posedge clk);
        @(negedge clk);
        chk_state(tag, v.exp_pc, v.exp_req, v.exp_trap, v.exp_halted, v.exp_instret, v.exp_epc);
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, PC_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // args: ack sel br imm rs1 eb res | epc req trap halted instret pc
        // Boot edge (ack ignored), then four sequential retires.
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd0,  32'h0000_0000));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd1,  32'h0000_0004));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd2,  32'h0000_0008));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd3,  32'h0000_000C));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd4,  32'h0000_0010));
        // Stall three cycles with a taken branch pending, then backward branch.
        tbl.push_back(mk(0, PC_BR,   1, 32'hFFFF_FFF8, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd4,  32'h0000_0010));
        tbl.push_back(mk(0, PC_BR,   1, 32'hFFFF_FFF8, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd4,  32'h0000_0010));
        tbl.push_back(mk(0, PC_BR,   1, 32'hFFFF_FFF8, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd4,  32'h0000_0010));
        tbl.push_back(mk(1, PC_BR,   1, 32'hFFFF_FFF8, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd5,  32'h0000_0008));
        // JAL to 0x20, then JALR to 0x102 traps.
        tbl.push_back(mk(1, PC_JAL,  0, 32'h0000_0018, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'd6,  32'h0000_0020));
        tbl.push_back(mk(1, PC_JALR, 0, 32'h0,         32'h0000_0103, 0, 0, 32'h20,  1, 1, 0, 32'd6,  32'h0000_0100));
        tbl.push_back(mk(0, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h20,  1, 0, 0, 32'd6,  32'h0000_0100));
        // JAL back to 0x40, then EBREAK and five halted cycles with ack toggling.
        tbl.push_back(mk(1, PC_JAL,  0, 32'hFFFF_FF40, 32'h0,         0, 0, 32'h20,  1, 0, 0, 32'd7,  32'h0000_0040));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         1, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(0, PC_JAL,  0, 32'h0000_0100, 32'h0,         0, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(1, PC_JAL,  0, 32'h0000_0100, 32'h0,         0, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(0, PC_JAL,  0, 32'h0000_0100, 32'h0,         0, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(1, PC_JAL,  0, 32'h0000_0100, 32'h0,         0, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(0, PC_JAL,  0, 32'h0000_0100, 32'h0,         0, 0, 32'h20,  0, 0, 1, 32'd8,  32'h0000_0040));
        tbl.push_back(mk(0, PC_SEQ,  0, 32'h0,         32'h0,         0, 1, 32'h20,  1, 0, 0, 32'd8,  32'h0000_0044));
        // Resume while running is ignored; the retire proceeds normally.
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 1, 32'h20,  1, 0, 0, 32'd9,  32'h0000_0048));
        // Wrap at the top of the address space, not-taken branch with odd imm.
        tbl.push_back(mk(1, PC_JALR, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'h20,  1, 0, 0, 32'd10, 32'hFFFF_FFFC));
        tbl.push_back(mk(1, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h20,  1, 0, 0, 32'd11, 32'h0000_0000));
        tbl.push_back(mk(1, PC_BR,   0, 32'h0000_0002, 32'h0,         0, 0, 32'h20,  1, 0, 0, 32'd12, 32'h0000_0004));
        // Taken branch to bit1 target, then JAL to bit0 target: back-to-back traps.
        tbl.push_back(mk(1, PC_BR,   1, 32'h0000_0002, 32'h0,         0, 0, 32'h4,   1, 1, 0, 32'd12, 32'h0000_0100));
        tbl.push_back(mk(1, PC_JAL,  0, 32'h0000_0001, 32'h0,         0, 0, 32'h100, 1, 1, 0, 32'd12, 32'h0000_0100));
        tbl.push_back(mk(0, PC_SEQ,  0, 32'h0,         32'h0,         0, 0, 32'h100, 1, 0, 0, 32'd12, 32'h0000_0100));
        // EBREAK outranks a misaligned target, then resume.
        tbl.push_back(mk(1, PC_JAL,  0, 32'h0000_0002, 32'h0,         1, 0, 32'h100, 0, 0, 1, 32'd13, 32'h0000_0100));
        tbl.push_back(mk(0, PC_SEQ,  0, 32'h0,         32'h0,         0, 1, 32'h100, 1, 0, 0, 32'd13, 32'h0000_0104));

        rst = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        rst = 1'b0;
        chk_state("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // Rebuild pc=0x80, instret=7 from a fresh reset, then reset mid-stall.
        rst = 1'b1;
        drive(idle);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1, PC_SEQ, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd0, 32'h0), "r_boot");
        for (int i = 1; i <= 6; i++)
            run_vec(mk(1, PC_SEQ, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, i, 4 * i), $sformatf("r_seq%0d", i));
        run_vec(mk(1, PC_JAL, 0, 32'h68, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd7, 32'h80), "r_jal");
        run_vec(mk(0, PC_SEQ, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd7, 32'h80), "r_stall");

        bus.fetch_ack = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_state("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        bus.fetch_ack = 1'b1;
        bus.resume    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_state("rst_vs_resume", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        drive(idle);
        rst = 1'b0;
        chk_state("reboot", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        run_vec(mk(1, PC_SEQ, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd0, 32'h0), "reboot_edge");
        run_vec(mk(1, PC_SEQ, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 32'd1, 32'h4), "reboot_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the program counter and sequences instruction fetch for the single-cycle RV32I core.
- Selects the next PC from sequential, branch, JAL, JALR, trap or resume sources.
- Handshakes each fetch with instruction memory, traps misaligned targets, halts on EBREAK and counts retired instructions.
- Sits between instruction memory and the decode/execute datapath. It replaces the free-running +4 counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned-target trap; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  out  1  fetch request valid; fetch_addr is stable while it is high.
- fetch_addr  out  32  address of the instruction being fetched; equals pc.
- fetch_ack  in  1  imem has returned the instruction at fetch_addr this cycle.
- pc_sel  in  2  next-PC source from decode: 0 SEQ, 1 BR, 2 JAL, 3 JALR; sampled only on retire.
- br_taken  in  1  branch comparison result; used only when pc_sel=BR.
- imm  in  32  sign-extended immediate from decode.
- rs1_val  in  32  rs1 operand, used for JALR.
- ebreak  in  1  the current instruction is EBREAK.
- resume  in  1  leave HALT; takes effect only in HALT.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational; the link value for JAL/JALR.
- trap  out  1  one-cycle pulse when a misaligned target is detected.
- epc  out  32  PC of the faulting instruction, held until the next trap.
- halted  out  1  high while in HALT.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - pc=RESET_VECTOR, state=BOOT, epc=0, instret=0, trap=0, fetch_req=0, halted=0.
- States: BOOT, RUN, HALT.
  - BOOT: fetch_req=0 for exactly one cycle after reset deasserts, then go to RUN.
  - RUN: fetch_req=1, fetch_addr=pc.
  - retire = state==RUN && fetch_ack. No retire means all state holds (stall); imem latency is unbounded.
- Targets, computed combinationally from the current pc:
  - SEQ: pc+4.
  - BR: br_taken ? pc+imm : pc+4.
  - JAL: pc+imm.
  - JALR: (rs1_val+imm) & ~32'h1.
- Arithmetic: all adds are modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0 with no fault.
- Misaligned: the selected target has bit[1] set (bit[0] is always clear by construction for JALR; a bit[0] from BR/JAL also counts as misaligned).
- On retire, apply the first matching case in this priority order:
  1. ebreak: pc unchanged, state goes to HALT, instret increments.
  2. misaligned target: pc=TRAP_VECTOR, epc=pc, trap=1 for one cycle, instret does not increment.
  3. otherwise: pc=target, instret increments (wraps at 2^32).
- HALT: fetch_req=0 and halted=1. fetch_ack and pc_sel are ignored.
  - resume: next edge sets pc=pc+4 and state=RUN.
- resume outside HALT is ignored. resume together with rst: rst wins.
- A fetch_ack arriving in BOOT or HALT is ignored.
- pc and fetch_addr are registered, so the new pc is visible the cycle after retire. pc_plus4 follows pc combinationally.

Decomposition:
- Package pc_seq_pkg:
  - pc_sel encoding: PC_SEQ, PC_BR, PC_JAL, PC_JALR.
  - State enum: BOOT, RUN, HALT.
  - Default RESET_VECTOR and TRAP_VECTOR constants.
  - Also imported by decode to drive pc_sel.
- Sub-module pc_target_calc: purely combinational.
  - Inputs: pc, pc_sel, br_taken, imm, rs1_val.
  - Outputs: target, misaligned.
  - pc_sequencer holds the FSM, PC, epc and instret registers.

Test Plan:
1. Reset, then fetch_ack tied high with pc_sel=SEQ for 4 cycles → BOOT lasts 1 cycle with fetch_req=0; fetch_addr runs 0,4,8,C; instret=4.
2. At pc=0x10, fetch_ack=0 for 3 cycles, then 1 with BR, br_taken=1, imm=-8 → pc holds 0x10 during the stall, then becomes 0x08; instret +1.
3. At pc=0x20, JALR with rs1_val=0x103, imm=0 → pc=0x102 is misaligned (bit1) → trap pulse, epc=0x20, pc=0x100, instret unchanged.
4. At pc=0x40, ebreak=1 → halted=1 and fetch_req=0 for 5 cycles while fetch_ack toggles; resume → pc=0x44 and RUN.
5. pc=0xFFFF_FFFC with SEQ retire → pc=0x0000_0000, no trap; BR with br_taken=0 and imm=2 → pc+4, no trap.
6. Assert rst mid-stall at pc=0x80 with instret=7 → pc=RESET_VECTOR and instret=0 immediately; BOOT repeats for 1 cycle.
